// File: rtl/click_emitter_pkg.sv
// click_pkg: shared state encoding and constants for the click_emitter block.
package click_pkg;

    // Emitter phases: waiting, driving the pulse, enforcing the low gap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        DEAD = 2'd2
    } click_state_t;

    // Shortest high or low phase; a programmed 0 is raised to this.
    localparam int CLICK_MIN_CYCLES = 1;

endpackage

// File: rtl/click_emitter_if.sv
// click_emitter_if: request/configuration inputs, pulse outputs and debug view
// of the click_emitter.
//
// Handshake: fire is a one-cycle strobe with no ready. It is sampled on every
// rising edge. A strobe that arrives while a pulse is in progress is either
// queued (pending counter build) or discarded. A discarded strobe is reported
// on dropped one cycle later. There is no back-pressure path.
interface click_emitter_if #(
    parameter int W = 8
);
    import click_pkg::*;

    logic         fire;
    logic [W-1:0] pulse_width;
    logic [W-1:0] dead_time;
    logic         click;
    logic         busy;
    logic         dropped;
    // Debug view of the FSM and the shared phase timer.
    click_state_t state;
    logic [W-1:0] timer;

    modport master (
        output fire, pulse_width, dead_time,
        input  click, busy, dropped, state, timer
    );

    modport slave (
        input  fire, pulse_width, dead_time,
        output click, busy, dropped, state, timer
    );
endinterface

// File: rtl/click_emitter_timer.sv
// click_timer: W-bit loadable down-counter shared by the HIGH and DEAD phases.
// expire flags the last cycle of a phase (count == 1). The counter rests at 0
// when nothing is running.
module click_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         expire
);
    logic [W-1:0] count;

    // Load wins over counting; count down to zero and hold there.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign value  = count;
    assign expire = (count == W'(1));
endmodule

// File: rtl/click_emitter.sv
// click_emitter: turns one-cycle fire requests into high pulses of programmed
// width, each followed by a programmed low dead time.
// Build option: define CLICK_EMITTER_PEND_EN to queue requests that arrive
// while a pulse is in progress (up to PEND_MAX). Without it, every such request
// is dropped.
module click_emitter
    import click_pkg::*;
#(
    parameter int W        = 8,
    parameter int PEND_MAX = 15
) (
    input  logic            clock,
    input  logic            reset_n,
    click_emitter_if.slave  bus
);
    click_state_t state, state_next;
    logic         start;
    logic         drop;
    logic         tmr_load;
    logic [W-1:0] tmr_value;
    logic [W-1:0] tmr_count;
    logic         tmr_expire;
    logic [W-1:0] dead_lat;
    logic         click_q;
    logic         busy_q;
    logic         dropped_q;

`ifdef CLICK_EMITTER_PEND_EN
    localparam logic [7:0] PEND_LIMIT = 8'(PEND_MAX);
    logic [7:0] pend, pend_next;
`else
    // Queue depth has no meaning without the pending counter.
    logic unused_pend_max;
    assign unused_pend_max = (PEND_MAX != 0);
`endif

    // A programmed zero still gives a one-cycle phase.
    function automatic logic [W-1:0] clamp_min(input logic [W-1:0] v);
        return (v == '0) ? W'(CLICK_MIN_CYCLES) : v;
    endfunction

    click_timer #(.W(W)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .value      (tmr_count),
        .expire     (tmr_expire)
    );

    // Next state, timer loads, queue update and drop decision.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        drop       = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = '0;
`ifdef CLICK_EMITTER_PEND_EN
        pend_next  = pend;
`endif
        unique case (state)
            IDLE: begin
                if (bus.fire) start = 1'b1;
            end
            HIGH: begin
                if (tmr_expire) begin
                    state_next = DEAD;
                    tmr_load   = 1'b1;
                    tmr_value  = clamp_min(dead_lat);
                end
`ifdef CLICK_EMITTER_PEND_EN
                if (bus.fire) begin
                    if (pend == PEND_LIMIT) drop = 1'b1;
                    else                    pend_next = pend + 8'd1;
                end
`else
                if (bus.fire) drop = 1'b1;
`endif
            end
            DEAD: begin
`ifdef CLICK_EMITTER_PEND_EN
                if (tmr_expire) begin
                    // A fire landing on the exit edge is consumed at once, so
                    // the queue depth is left as it was and nothing is lost.
                    if (pend != 8'd0 || bus.fire) begin
                        start = 1'b1;
                        if (!bus.fire) pend_next = pend - 8'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bus.fire) begin
                    if (pend == PEND_LIMIT) drop = 1'b1;
                    else                    pend_next = pend + 8'd1;
                end
`else
                if (tmr_expire) state_next = IDLE;
                if (bus.fire)   drop = 1'b1;
`endif
            end
            default: state_next = IDLE;
        endcase
        // Starting a pulse always reloads from the live width input.
        if (start) begin
            state_next = HIGH;
            tmr_load   = 1'b1;
            tmr_value  = clamp_min(bus.pulse_width);
        end
    end

    // FSM state and pending depth.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
`ifdef CLICK_EMITTER_PEND_EN
            pend  <= 8'd0;
`endif
        end else begin
            state <= state_next;
`ifdef CLICK_EMITTER_PEND_EN
            pend  <= pend_next;
`endif
        end
    end

    // Dead time is captured when the pulse starts so later input changes are ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   dead_lat <= '0;
        else if (start) dead_lat <= bus.dead_time;
    end

    // Registered outputs follow the state one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            click_q   <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            click_q   <= (state == HIGH);
            busy_q    <= (state != IDLE);
            dropped_q <= drop;
        end
    end

    assign bus.click   = click_q;
    assign bus.busy    = busy_q;
    assign bus.dropped = dropped_q;
    assign bus.state   = state;
    assign bus.timer   = tmr_count;
endmodule
